// File: rtl/maxpool2x2_if.sv
// Pixel stream between the ReLU stage, the 2x2 max-pool stage and the next layer.
// The master drives pixels in and observes pooled results. The slave is the pooling block.
interface maxpool2x2_if #(
  parameter int INPUT_NUM = 6,
  parameter int WDP       = 9
);
  logic                     en;
  logic [WDP*INPUT_NUM-1:0] data_i;
  logic                     q_en;
  logic [WDP*INPUT_NUM-1:0] q;
  logic                     frame_done;

  modport master (output en, data_i, input q_en, q, frame_done);
  modport slave  (input en, data_i, output q_en, q, frame_done);
endinterface

// File: rtl/maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pooling over INPUT_NUM parallel signed planes.
// Pixels arrive in raster order, one per en cycle, with no backpressure.
// The horizontal pair max goes into a half-width line buffer on even rows.
// On odd rows, that buffer entry is combined with the new pair to form the pooled output.
module maxpool2x2 #(
  parameter int INPUT_NUM = 6,
  parameter int WDP       = 9,
  parameter int IMG_W     = 24,
  parameter int IMG_H     = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  maxpool2x2_if.slave  bus
);
  localparam int DW = WDP * INPUT_NUM;
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int HW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
    $error("maxpool2x2: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
    $error("maxpool2x2: IMG_H must be even and >= 2");
  end

  typedef logic signed [WDP-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] half;
  logic          accept;
  logic          col_odd;
  logic          row_odd;
  logic          col_last;
  logic          row_last;

  sample_t       hold [INPUT_NUM];
  sample_t       lbuf [INPUT_NUM][IMG_W/2];
  sample_t       d    [INPUT_NUM];
  sample_t       h    [INPUT_NUM];
  sample_t       m    [INPUT_NUM];
  logic [DW-1:0] q_nxt;

  // Decode the current pixel position. A clr cycle never accepts its pixel.
  always_comb begin
    accept   = bus.en && !clr;
    col_odd  = col[0];
    row_odd  = row[0];
    col_last = (col == CW'(IMG_W - 1));
    row_last = (row == RW'(IMG_H - 1));
    half     = HW'(col >> 1);
  end

  // Unpack the planes and compute the horizontal pair max and the full window max.
  always_comb begin
    // NOTE: q_nxt gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    q_nxt = '0;
    for (int p = 0; p < INPUT_NUM; p++) begin
      d[p] = sample_t'(bus.data_i[DW-1-p*WDP -: WDP]);
      h[p] = smax(hold[p], d[p]);
      m[p] = smax(lbuf[p][half], h[p]);
      q_nxt[DW-1-p*WDP -: WDP] = m[p];
    end
  end

  // Track the raster position. Bubbles leave it unchanged, and clr restarts the frame.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: all state in always_ff uses non-blocking assignments, so every reader sees the pre-edge value.
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (bus.en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Capture the left pixel of each horizontal pair.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < INPUT_NUM; p++) hold[p] <= '0;
    end else if (accept && !col_odd) begin
      for (int p = 0; p < INPUT_NUM; p++) hold[p] <= d[p];
    end
  end

  // Store the top-row pair max for the window directly below.
  // NOTE: the line buffer has no reset. Every entry is written on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      for (int p = 0; p < INPUT_NUM; p++) lbuf[p][half] <= h[p];
    end
  end

  // Register the pooled pixel, its valid pulse and the end-of-frame flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.q_en       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.q          <= '0;
    end else begin
      bus.q_en       <= accept && col_odd && row_odd;
      bus.frame_done <= accept && col_last && row_last;
      if (accept && col_odd && row_odd) bus.q <= q_nxt;
    end
  end
endmodule

// File: tb/tb_maxpool2x2.sv
// Self-checking bench for maxpool2x2 on a 4x4 frame with two 9-bit planes.
// The reference model keeps the whole frame in an array.
// It pools each 2x2 window with plain integer max when the window's last pixel arrives.
module tb_maxpool2x2;
  localparam int N  = 2;
  localparam int W  = 9;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NP = IW * IH;

  logic clk = 1'b0;
  logic rstn;
  logic clr;

  maxpool2x2_if #(.INPUT_NUM(N), .WDP(W)) bus ();

  maxpool2x2 #(.INPUT_NUM(N), .WDP(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int           pix0 [IH][IW];
  int           pix1 [IH][IW];
  int           mrow, mcol;
  logic         exp_qen, exp_fd;
  logic [2*W-1:0] exp_q;
  logic [2*W-1:0] outs [$];
  int           qen_count, fd_count;
  int           fr0 [NP];
  int           fr1 [NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int r;
    r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    if (d > r) r = d;
    return r;
  endfunction

  function automatic logic [2*W-1:0] pack2(input int a, input int b);
    return {W'(a), W'(b)};
  endfunction

  function automatic int rnd_s9();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic model_reset();
    mrow  = 0;
    mcol  = 0;
    exp_q = '0;
  endtask

  // One clock cycle: drive the inputs, predict with the model, then check the outputs after the edge.
  task automatic step(input logic e, input logic c, input int v0, input int v1);
    bus.en     = e;
    clr        = c;
    bus.data_i = pack2(v0, v1);
    exp_qen    = 1'b0;
    exp_fd     = 1'b0;
    if (c) begin
      mrow = 0;
      mcol = 0;
    end else if (e) begin
      pix0[mrow][mcol] = v0;
      pix1[mrow][mcol] = v1;
      if ((mrow % 2) == 1 && (mcol % 2) == 1) begin
        exp_qen = 1'b1;
        exp_fd  = (mrow == IH - 1) && (mcol == IW - 1);
        exp_q   = pack2(max4(pix0[mrow-1][mcol-1], pix0[mrow-1][mcol], pix0[mrow][mcol-1], pix0[mrow][mcol]),
                        max4(pix1[mrow-1][mcol-1], pix1[mrow-1][mcol], pix1[mrow][mcol-1], pix1[mrow][mcol]));
      end
      mcol++;
      if (mcol == IW) begin
        mcol = 0;
        mrow = (mrow + 1) % IH;
      end
    end
    @(posedge clk);
    #1;
    check("q_en", 64'(bus.q_en), 64'(exp_qen));
    check("frame_done", 64'(bus.frame_done), 64'(exp_fd));
    check("q", 64'(bus.q), 64'(exp_q));
    if (bus.q_en) begin
      outs.push_back(bus.q);
      qen_count++;
    end
    if (bus.frame_done) fd_count++;
  endtask

  task automatic send_frame(input int npix, input int bubble_pct);
    for (int i = 0; i < npix; i++) begin
      if (int'($urandom_range(0, 99)) < bubble_pct)
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, rnd_s9(), rnd_s9());
      step(1'b1, 1'b0, fr0[i], fr1[i]);
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < NP; i++) begin
      fr0[i] = i;
      fr1[i] = NP - 1 - i;
    end
  endtask

  task automatic clear_stats();
    outs.delete();
    qen_count = 0;
    fd_count  = 0;
  endtask

  // Compare four captured outputs starting at `first` against the fixed basic-frame results.
  task automatic check_basic_outs(input string tag, input int first);
    logic [2*W-1:0] golden [4];
    golden[0] = pack2(5, 15);
    golden[1] = pack2(7, 13);
    golden[2] = pack2(13, 7);
    golden[3] = pack2(15, 5);
    check({tag, "_count"}, 64'(outs.size()), 64'(first + 4));
    for (int i = 0; i < 4; i++)
      if (first + i < outs.size()) check({tag, "_q"}, 64'(outs[first+i]), 64'(golden[i]));
  endtask

  initial begin
    rstn       = 1'b0;
    clr        = 1'b0;
    bus.en     = 1'b0;
    bus.data_i = '0;
    model_reset();
    clear_stats();
    #12;
    check("rst_q_en", 64'(bus.q_en), 64'(0));
    check("rst_q", 64'(bus.q), 64'(0));
    check("rst_frame_done", 64'(bus.frame_done), 64'(0));
    rstn = 1'b1;

    // Test 1: basic frame with continuous en.
    set_basic();
    clear_stats();
    send_frame(NP, 0);
    check_basic_outs("basic", 0);
    check("basic_fd", 64'(fd_count), 64'(1));

    // Test 2: same frame with random bubbles.
    clear_stats();
    send_frame(NP, 50);
    check_basic_outs("bubbles", 0);
    check("bubbles_fd", 64'(fd_count), 64'(1));

    // Test 3: signed compares in the first window of each plane.
    for (int i = 0; i < NP; i++) begin
      fr0[i] = rnd_s9();
      fr1[i] = rnd_s9();
    end
    fr0[0] = -3;  fr0[1] = -1; fr0[4] = -256; fr0[5] = -7;
    fr1[0] = 255; fr1[1] = -1; fr1[4] = 0;    fr1[5] = 1;
    clear_stats();
    send_frame(NP, 20);
    check("signed_count", 64'(outs.size()), 64'(4));
    if (outs.size() > 0) begin
      check("signed_neg", 64'(outs[0][2*W-1:W]), 64'(9'h1FF));
      check("signed_pos", 64'(outs[0][W-1:0]), 64'(255));
    end

    // Test 4: back-to-back frames; a large first frame must not leak into the second.
    for (int i = 0; i < NP; i++) begin
      fr0[i] = 255;
      fr1[i] = 255;
    end
    clear_stats();
    send_frame(NP, 0);
    set_basic();
    send_frame(NP, 0);
    check("b2b_fd", 64'(fd_count), 64'(2));
    check("b2b_qen", 64'(qen_count), 64'(8));
    check_basic_outs("b2b", 4);

    // Test 5: clr after 6 pixels with en high in the same cycle, then a full frame.
    set_basic();
    send_frame(6, 0);
    step(1'b1, 1'b1, 99, 99);
    clear_stats();
    send_frame(NP, 0);
    check_basic_outs("clr", 0);
    check("clr_fd", 64'(fd_count), 64'(1));

    // Test 6: async reset during row 1, right after the first window's q_en pulse.
    send_frame(6, 0);
    check("pre_rst_q_en", 64'(bus.q_en), 64'(1));
    bus.en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_q_en", 64'(bus.q_en), 64'(0));
    check("async_q", 64'(bus.q), 64'(0));
    check("async_frame_done", 64'(bus.frame_done), 64'(0));
    #1 rstn = 1'b1;
    model_reset();
    clear_stats();
    send_frame(NP, 0);
    check_basic_outs("post_rst", 0);

    // Random traffic: random data, bubbles and occasional clr.
    clear_stats();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0), rnd_s9(), rnd_s9());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
